alu_op_sequencer: RTL and testbench

Upstream issue stage for the 4-bit gate-level ALU. Accepts ALU operations (select code plus A/B/C operands) over a valid/ready handshake, buffers them in a small FIFO, and drives them one at a time onto the ALU's Select/A/B/C inputs. Holds each operation stable for a programmable number of settle cycles to cover the ALU's gate delays, then captures RegOut/Carryout and presents them downstream over a second valid/ready handshake.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/seq_fifo.sv | 54 +++++
 rtl/alu_op_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: op codes, FSM states,
// operand geometry and the packed FIFO entry layout.
package alu_seq_pkg;

    localparam int OPER_W  = 4;
    localparam int SEL_W   = 3;
    localparam int ENTRY_W = SEL_W + 3 * OPER_W;

    localparam logic [SEL_W-1:0] OP_NOTA = 3'b000;
    localparam logic [SEL_W-1:0] OP_ADD  = 3'b001;
    localparam logic [SEL_W-1:0] OP_AND  = 3'b010;
    localparam logic [SEL_W-1:0] OP_OR   = 3'b011;
    localparam logic [SEL_W-1:0] OP_XOR  = 3'b100;
    localparam logic [SEL_W-1:0] OP_SHL  = 3'b101;
    localparam logic [SEL_W-1:0] OP_ZERO = 3'b110;
    localparam logic [SEL_W-1:0] OP_ONES = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seqState_t;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [OPER_W-1:0] a;
        logic [OPER_W-1:0] b;
        logic [OPER_W-1:0] c;
    } aluOp_t;

endpackage

// File: rtl/seq_fifo.sv
// Synchronous FIFO for pending ALU operations. Head is read combinationally;
// a push is refused when full regardless of a same-cycle pop.
module seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 4-bit gate-level ALU: queues operations, holds each on
// the ALU inputs for SETTLE_CYCLES, then captures and hands off the result.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_select,
    input  logic [OPER_W-1:0]       in_a,
    input  logic [OPER_W-1:0]       in_b,
    input  logic [OPER_W-1:0]       in_c,

    output logic [SEL_W-1:0]        alu_select,
    output logic [OPER_W-1:0]       alu_a,
    output logic [OPER_W-1:0]       alu_b,
    output logic [OPER_W-1:0]       alu_c,
    input  logic [OPER_W-1:0]       alu_regout,
    input  logic                    alu_carryout,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OPER_W-1:0]       out_result,
    output logic                    out_carry,
    output logic [SEL_W-1:0]        out_select,

    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    seqState_t        state;
    seqState_t        stateNext;
    logic [CNT_W-1:0] settleCnt;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             popHead;
    logic             captureResult;
    aluOp_t           inOp;
    aluOp_t           headOp;

    assign inOp = '{sel: in_select, a: in_a, b: in_b, c: in_c};

    seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) uFifo (
        .clock  (clock),
        .reset  (reset),
        .push   (in_valid),
        .wrData (inOp),
        .pop    (popHead),
        .rdData (headOp),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (count)
    );

    assign in_ready  = !fifoFull;
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);

    // HOLD may issue the next op on the same edge its result is taken,
    // so a busy stream never passes through IDLE.
    always_comb begin
        stateNext     = state;
        popHead       = 1'b0;
        captureResult = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    popHead   = 1'b1;
                    stateNext = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settleCnt == CNT_ONE) begin
                    captureResult = 1'b1;
                    stateNext     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (!fifoEmpty) begin
                        popHead   = 1'b1;
                        stateNext = ST_SETTLE;
                    end else begin
                        stateNext = ST_IDLE;
                    end
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            settleCnt <= '0;
        end else begin
            state <= stateNext;
            if (popHead) begin
                settleCnt <= SETTLE_LOAD;
            end else if (state == ST_SETTLE) begin
                settleCnt <= settleCnt - 1'b1;
            end
        end
    end

    // ALU drive registers change only on an issue edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_select <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_c      <= '0;
        end else if (popHead) begin
            alu_select <= headOp.sel;
            alu_a      <= headOp.a;
            alu_b      <= headOp.b;
            alu_c      <= headOp.c;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_result <= '0;
            out_carry  <= 1'b0;
            out_select <= '0;
        end else if (captureResult) begin
            out_result <= alu_regout;
            out_carry  <= alu_carryout;
            out_select <= alu_select;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU closing the loop.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_select = '0;
    logic [3:0] in_a = '0, in_b = '0, in_c = '0;
    logic [2:0] alu_select;
    logic [3:0] alu_a, alu_b, alu_c;
    logic [3:0] alu_regout;
    logic       alu_carryout;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_result;
    logic       out_carry;
    logic [2:0] out_select;
    logic       busy;
    logic [2:0] count;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    alu_op_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_regout(alu_regout), .alu_carryout(alu_carryout),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_select(out_select),
        .busy(busy), .count(count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural model of the gate-level ALU
    logic [4:0] sumAbc;
    always_comb begin
        sumAbc       = {1'b0, alu_a} + {1'b0, alu_b} + {1'b0, alu_c};
        alu_regout   = 4'h0;
        alu_carryout = 1'b0;
        case (alu_select)
            OP_NOTA: alu_regout = ~alu_a;
            OP_ADD:  begin alu_regout = sumAbc[3:0]; alu_carryout = sumAbc[4]; end
            OP_AND:  alu_regout = alu_a & alu_b;
            OP_OR:   alu_regout = alu_a | alu_b;
            OP_XOR:  alu_regout = alu_a ^ alu_b;
            OP_SHL:  begin alu_regout = {alu_a[2:0], alu_c[0]}; alu_carryout = alu_a[3]; end
            OP_ZERO: alu_regout = 4'h0;
            OP_ONES: alu_regout = 4'hF;
            default: alu_regout = 4'h0;
        endcase
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pushOp(input logic [2:0] sel, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] c);
        int guard = 0;
        in_valid = 1'b1; in_select = sel; in_a = a; in_b = b; in_c = c;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            checks++; fails++;
            $display("FAIL push_timeout: in_ready=%b required 1 within 100 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitValid(output bit ok);
        int guard = 0;
        while (!out_valid && guard < 100) begin
            tick();
            guard++;
        end
        ok = out_valid;
        if (!ok) begin
            checks++; fails++;
            $display("FAIL result_timeout: out_valid=%b required 1 within 100 cycles", out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++;
            $display("FAIL reset_flags: out_valid=%b busy=%b want 0 0", out_valid, busy); end
        checks++; if ({alu_select, alu_a, alu_b, alu_c} !== 15'h0) begin fails++;
            $display("FAIL reset_alu: got %h want 0", {alu_select, alu_a, alu_b, alu_c}); end
        checks++; if ({out_result, out_carry, out_select} !== 8'h0) begin fails++;
            $display("FAIL reset_out: got %h want 0", {out_result, out_carry, out_select}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_op();
        int acc;
        out_ready = 1'b1;
        pushOp(OP_ADD, 4'd5, 4'd6, 4'd7);
        acc = cyc;
        checks++; if (count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d want 1", count); end
        tick();
        checks++; if ({alu_select, alu_a, alu_b, alu_c} !== {OP_ADD, 4'd5, 4'd6, 4'd7}) begin fails++;
            $display("FAIL single_issue: got %h want %h", {alu_select, alu_a, alu_b, alu_c}, {OP_ADD, 4'd5, 4'd6, 4'd7}); end
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin fails++;
            $display("FAIL single_early: out_valid=%b at +%0d want 0", out_valid, cyc - acc); end
        tick();
        checks++; if (out_valid !== 1'b1 || cyc - acc !== SETTLE + 1) begin fails++;
            $display("FAIL single_latency: out_valid=%b at +%0d want 1 at +%0d", out_valid, cyc - acc, SETTLE + 1); end
        checks++; if ({out_result, out_carry, out_select} !== {4'h2, 1'b1, OP_ADD}) begin fails++;
            $display("FAIL single_result: got %h want %h", {out_result, out_carry, out_select}, {4'h2, 1'b1, OP_ADD}); end
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++;
            $display("FAIL single_drain: out_valid=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int got = 0;
        bit unstable = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) pushOp(OP_XOR, 4'hA, 4'h6, 4'(i));
        checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin fails++;
            $display("FAIL bp_full: count=%0d in_ready=%b want 4 0", count, in_ready); end
        in_valid = 1'b1; in_select = OP_ONES; in_a = 4'h1; in_b = 4'h1; in_c = 4'h1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_result !== 4'hC || out_carry !== 1'b0 ||
                out_select !== OP_XOR || count !== 3'd4 || in_ready !== 1'b0) unstable = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (unstable) begin fails++;
            $display("FAIL bp_hold: out_valid=%b result=%h count=%0d want 1 c 4 held", out_valid, out_result, count); end
        out_ready = 1'b1;
        for (int k = 0; k <= DEPTH; k++) begin
            waitValid(ok);
            if (!ok) break;
            checks++; if (out_result !== 4'hC || out_select !== OP_XOR) begin fails++;
                $display("FAIL bp_result%0d: got %h/%b want c/100", k, out_result, out_select); end
            got++;
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            if (out_valid) got++;
            tick();
        end
        checks++; if (got !== DEPTH + 1 || count !== 3'd0) begin fails++;
            $display("FAIL bp_total: results=%0d count=%0d want %0d 0", got, count, DEPTH + 1); end
    endtask

    localparam logic [2:0] S_SEL [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001};
    localparam logic [3:0] S_A   [8] = '{4'h3, 4'h9, 4'hC, 4'h5, 4'hF, 4'h6, 4'h7, 4'h3};
    localparam logic [3:0] S_B   [8] = '{4'h0, 4'h8, 4'hA, 4'hA, 4'h5, 4'h0, 4'h0, 4'h4};
    localparam logic [3:0] S_C   [8] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    localparam logic [3:0] S_RES [8] = '{4'hC, 4'h2, 4'h8, 4'hF, 4'hA, 4'hC, 4'h0, 4'h7};
    localparam logic       S_CY  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic test_back_to_back();
        int stamp [8];
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) pushOp(S_SEL[i], S_A[i], S_B[i], S_C[i]);
            end
            begin
                bit ok;
                for (int k = 0; k < 8; k++) begin
                    waitValid(ok);
                    stamp[k] = cyc;
                    if (!ok) break;
                    checks++; if ({out_result, out_carry, out_select} !== {S_RES[k], S_CY[k], S_SEL[k]}) begin fails++;
                        $display("FAIL stream_result%0d: got %h want %h", k, {out_result, out_carry, out_select}, {S_RES[k], S_CY[k], S_SEL[k]}); end
                    if (k > 0) begin
                        checks++; if (stamp[k] - stamp[k-1] !== SETTLE + 1) begin fails++;
                            $display("FAIL stream_spacing%0d: got %0d cycles want %0d", k, stamp[k] - stamp[k-1], SETTLE + 1); end
                    end
                    tick();
                end
            end
        join
        tick();
    endtask

    task automatic test_alu_stability();
        bit ok;
        bit moved = 1'b0;
        out_ready = 1'b0;
        pushOp(OP_AND, 4'hC, 4'hA, 4'h3);
        tick();
        checks++; if ({alu_select, alu_a, alu_b, alu_c} !== {OP_AND, 4'hC, 4'hA, 4'h3}) begin fails++;
            $display("FAIL stab_issue: got %h want %h", {alu_select, alu_a, alu_b, alu_c}, {OP_AND, 4'hC, 4'hA, 4'h3}); end
        pushOp(OP_OR, 4'h1, 4'h2, 4'h4);
        if ({alu_select, alu_a, alu_b, alu_c} !== {OP_AND, 4'hC, 4'hA, 4'h3}) moved = 1'b1;
        pushOp(OP_NOTA, 4'h7, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            if ({alu_select, alu_a, alu_b, alu_c} !== {OP_AND, 4'hC, 4'hA, 4'h3}) moved = 1'b1;
            tick();
        end
        checks++; if (moved) begin fails++;
            $display("FAIL stab_hold: alu=%h want %h", {alu_select, alu_a, alu_b, alu_c}, {OP_AND, 4'hC, 4'hA, 4'h3}); end
        checks++; if (out_valid !== 1'b1 || out_result !== 4'h8) begin fails++;
            $display("FAIL stab_first: out_valid=%b result=%h want 1 8", out_valid, out_result); end
        out_ready = 1'b1;
        tick();
        checks++; if ({alu_select, alu_a, alu_b, alu_c} !== {OP_OR, 4'h1, 4'h2, 4'h4}) begin fails++;
            $display("FAIL stab_next_issue: got %h want %h", {alu_select, alu_a, alu_b, alu_c}, {OP_OR, 4'h1, 4'h2, 4'h4}); end
        waitValid(ok);
        if (ok) begin
            checks++; if (out_result !== 4'h3) begin fails++; $display("FAIL stab_or: got %h want 3", out_result); end
            tick();
            waitValid(ok);
            if (ok) begin
                checks++; if (out_result !== 4'h8 || out_select !== OP_NOTA) begin fails++;
                    $display("FAIL stab_not: got %h/%b want 8/000", out_result, out_select); end
                tick();
            end
        end
    endtask

    task automatic test_reset_midop();
        bit seen = 1'b0;
        out_ready = 1'b1;
        pushOp(OP_ADD, 4'h1, 4'h1, 4'h0);
        pushOp(OP_OR, 4'h5, 4'h2, 4'h0);
        pushOp(OP_XOR, 4'h9, 4'h3, 4'h0);
        checks++; if (count !== 3'd2 || busy !== 1'b1 || out_valid !== 1'b0) begin fails++;
            $display("FAIL rst_pre: count=%0d busy=%b out_valid=%b want 2 1 0", count, busy, out_valid); end
        reset = 1'b1;
        tick();
        checks++; if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin fails++;
            $display("FAIL rst_ctrl: count=%0d in_ready=%b out_valid=%b busy=%b want 0 1 0 0", count, in_ready, out_valid, busy); end
        checks++; if ({alu_select, alu_a, alu_b, alu_c} !== 15'h0 || {out_result, out_carry, out_select} !== 8'h0) begin fails++;
            $display("FAIL rst_data: alu=%h out=%h want 0 0", {alu_select, alu_a, alu_b, alu_c}, {out_result, out_carry, out_select}); end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || busy) seen = 1'b1;
            tick();
        end
        checks++; if (seen) begin fails++; $display("FAIL rst_discard: activity after reset, want none"); end
    endtask

    task automatic test_shift_ones();
        bit ok;
        out_ready = 1'b1;
        pushOp(OP_SHL, 4'b1001, 4'h0, 4'h1);
        waitValid(ok);
        if (ok) begin
            checks++; if ({out_result, out_carry, out_select} !== {4'b0011, 1'b1, OP_SHL}) begin fails++;
                $display("FAIL shl_result: got %h want %h", {out_result, out_carry, out_select}, {4'b0011, 1'b1, OP_SHL}); end
            tick();
        end
        pushOp(OP_ONES, 4'h2, 4'h3, 4'h0);
        waitValid(ok);
        if (ok) begin
            checks++; if ({out_result, out_carry, out_select} !== {4'hF, 1'b0, OP_ONES}) begin fails++;
                $display("FAIL ones_result: got %h want %h", {out_result, out_carry, out_select}, {4'hF, 1'b0, OP_ONES}); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_backpressure();
        test_back_to_back();
        test_alu_stability();
        test_reset_midop();
        test_shift_ones();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
